ras_ckpt_stack: RTL
===================

// Module: ras_ckpt_stack
// PURPOSE
//  Parametrised return-address stack (RAS) for the frontend branch predictor. Adds speculative
//  checkpoint/restore, so a mispredicted branch can repair pointer, count and the overwritten top
//  entry in one cycle. Sits between the predecoder (push on call, pop on return) and the branch
//  unit (checkpoint at predicted branch, restore on mispredict). Sized from the core config RASDepth.
// PARAMETERS
//  VLEN     32  width of a stored return address
//  DEPTH    2   number of RAS entries (>=2, any integer; circular with explicit wrap)
//  NR_CKPT  4   number of checkpoint slots (>=1)
// PORTS
//  clk_i          in   1                   clock
//  rst_i          in   1                   reset, synchronous, active-high
//  push_i         in   1                   push push_addr_i (call predicted)
//  push_addr_i    in   VLEN                return address to push
//  pop_i          in   1                   pop top entry (return predicted)
//  top_o          out  VLEN                current top entry (registered storage, comb read)
//  top_valid_o    out  1                   count != 0
//  overflow_o     out  1                   1-cycle pulse: push while full, oldest entry lost
//  underflow_o    out  1                   1-cycle pulse: pop while empty
//  ckpt_req_i     in   1                   request a checkpoint of current state
//  ckpt_gnt_o     out  1                   a free slot exists (comb); checkpoint taken iff req&gnt
//  ckpt_id_o      out  $clog2(NR_CKPT)     lowest-index free slot (valid when gnt)
//  restore_i      in   1                   restore state from slot restore_id_i
//  restore_id_i   in   $clog2(NR_CKPT)     slot to restore
//  release_i      in   1                   free slot release_id_i without restoring
//  release_id_i   in   $clog2(NR_CKPT)     slot to free
//  flush_i        in   1                   invalidate all checkpoints (stack content kept)
// BEHAVIOUR
//  State: entries[DEPTH], tos (0..DEPTH-1), count (0..DEPTH), ckpt_valid[NR_CKPT], and per slot
//   {tos, count, top value}.
//  Reset (rst_i=1 at clk edge): entries, tos, count, ckpt_valid <= 0; so top_o=0, top_valid_o=0,
//   ckpt_gnt_o=1, ckpt_id_o=0, overflow_o=underflow_o=0. Reset wins over every other input.
//  Stack update (no restore_i), effective next cycle:
//   - push only: tos <= (tos==DEPTH-1)?0:tos+1; entries[new tos] <= push_addr_i;
//     count <= min(count+1,DEPTH); overflow_o <= (count==DEPTH).
//   - pop only, count>0: tos <= (tos==0)?DEPTH-1:tos-1; count <= count-1.
//   - pop only, count==0: no state change; underflow_o <= 1.
//   - push&pop: entries[tos] <= push_addr_i in place, tos and count unchanged; if count==0,
//     treated as push only (count <= 1).
//  Checkpoint: on ckpt_req_i&ckpt_gnt_o, slot ckpt_id_o <= {tos, count, entries[tos]} sampled
//   BEFORE this cycle's push/pop; ckpt_valid set. ckpt_req_i with gnt=0 is dropped; the requester
//   stalls.
//  Restore: restore_i with ckpt_valid[restore_id_i]=1 -> tos, count <= saved values;
//   entries[saved tos] <= saved top; slot freed. Push/pop of the same cycle are ignored, no
//   overflow/underflow pulse. Restore of an invalid slot is a no-op; push/pop then proceed.
//  Checkpoint in the restore cycle: snapshot is the pre-restore state and is still granted.
//  Release: clears ckpt_valid[release_id_i]; releasing a free slot is a no-op.
//  Free-slot vector is sampled pre-update. A slot released/restored this cycle is not
//   re-granted until the next cycle, so alloc never collides with a free of the same id.
//  flush_i: all ckpt_valid <= 0; an allocation in the same cycle is discarded; flush beats restore.
//  Latency: 0-cycle comb read of top_o; all updates visible the cycle after the edge.
// TESTING
//  1 DEPTH=2: push A,B,C -> cycle 3 overflow_o=1, top_o=C, count=2; pop,pop -> top_valid_o=0;
//    pop -> underflow_o=1.
//  2 push A, ckpt (id 0), push B, pop, push C (overwrites A's old slot... no, B's), restore 0
//    -> top_o=A, count=1, slot 0 free.
//  3 count=2 top=X; ckpt id0; same cycle push&pop Y -> top_o=Y; restore 0 -> top_o=X, count=2.
//  4 NR_CKPT=4: 4 ckpt reqs -> ids 0,1,2,3; 5th -> gnt=0; release 2 -> next cycle id=2, gnt=1.
//  5 restore_i + push_i same cycle -> push ignored, no overflow; flush_i+restore_i -> only flush.
//  6 rst_i asserted mid-sequence with push_i=1 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/ras_ckpt_stack.sv
// Return-address stack for the frontend predictor, with speculative checkpoints.
// Push on predicted call, pop on predicted return. Each checkpoint slot saves
// {tos, count, top entry}. Restoring a slot repairs the pointer, the count and
// the one entry a wrong-path push may have overwritten, all in a single cycle.
module ras_ckpt_stack #(
    parameter int VLEN    = 32,
    parameter int DEPTH   = 2,
    parameter int NR_CKPT = 4,
    localparam int IDW    = (NR_CKPT > 1) ? $clog2(NR_CKPT) : 1,
    localparam int TW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [VLEN-1:0] push_addr_i,
    input  logic            pop_i,
    output logic [VLEN-1:0] top_o,
    output logic            top_valid_o,
    output logic            overflow_o,
    output logic            underflow_o,
    input  logic            ckpt_req_i,
    output logic            ckpt_gnt_o,
    output logic [IDW-1:0]  ckpt_id_o,
    input  logic            restore_i,
    input  logic [IDW-1:0]  restore_id_i,
    input  logic            release_i,
    input  logic [IDW-1:0]  release_id_i,
    input  logic            flush_i
);

    // Slot arrays are sized to the full id range. Ids at or above NR_CKPT are
    // never allocated, so their valid bit stays 0 and a restore of one is a no-op.
    localparam int NSLOT = 1 << IDW;

    // Handshake: a checkpoint is taken exactly in a cycle where ckpt_req_i and
    // ckpt_gnt_o are both high. ckpt_gnt_o and ckpt_id_o depend on registered
    // state only, so a requester without a grant simply holds ckpt_req_i.

    logic [VLEN-1:0] r_ent [DEPTH];
    logic [TW-1:0]   r_tos;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic            r_unf;
    logic [NSLOT-1:0] r_cv;
    logic [TW-1:0]   r_ck_tos [NSLOT];
    logic [CW-1:0]   r_ck_cnt [NSLOT];
    logic [VLEN-1:0] r_ck_top [NSLOT];

    logic            w_gnt;
    logic [IDW-1:0]  w_id;
    logic            w_take;
    logic            w_restore_ok;
    logic [TW-1:0]   w_tos_inc;
    logic [TW-1:0]   w_tos_dec;
    logic [TW-1:0]   w_tos_n;
    logic [CW-1:0]   w_cnt_n;
    logic            w_wr_en;
    logic [TW-1:0]   w_wr_idx;
    logic [VLEN-1:0] w_wr_data;
    logic            w_ovf_n;
    logic            w_unf_n;
    logic [NSLOT-1:0] w_cv_n;

    // Lowest-index free slot, taken from the valid vector as it was before this edge.
    always_comb begin
        w_gnt = 1'b0;
        w_id  = '0;
        for (int i = NR_CKPT - 1; i >= 0; i--) begin
            if (!r_cv[i]) begin
                w_gnt = 1'b1;
                w_id  = IDW'(i);
            end
        end
    end

    // Flush discards any allocation and beats a restore in the same cycle.
    assign w_take       = ckpt_req_i & w_gnt & ~flush_i;
    assign w_restore_ok = restore_i & r_cv[restore_id_i] & ~flush_i;
    assign w_tos_inc    = (r_tos == TW'(DEPTH - 1)) ? '0 : r_tos + TW'(1);
    assign w_tos_dec    = (r_tos == '0) ? TW'(DEPTH - 1) : r_tos - TW'(1);

    // Next stack state. A valid restore overrides push/pop, and push&pop on an
    // empty stack acts as a plain push.
    always_comb begin
        w_tos_n   = r_tos;
        w_cnt_n   = r_cnt;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_tos;
        w_wr_data = push_addr_i;
        w_ovf_n   = 1'b0;
        w_unf_n   = 1'b0;
        if (w_restore_ok) begin
            w_tos_n   = r_ck_tos[restore_id_i];
            w_cnt_n   = r_ck_cnt[restore_id_i];
            w_wr_en   = 1'b1;
            w_wr_idx  = r_ck_tos[restore_id_i];
            w_wr_data = r_ck_top[restore_id_i];
        end else if (push_i && (!pop_i || r_cnt == '0)) begin
            w_tos_n  = w_tos_inc;
            w_wr_en  = 1'b1;
            w_wr_idx = w_tos_inc;
            w_ovf_n  = (r_cnt == CW'(DEPTH));
            if (r_cnt != CW'(DEPTH)) begin
                w_cnt_n = r_cnt + CW'(1);
            end
        end else if (push_i) begin
            // push&pop with a non-empty stack: replace the top in place
            w_wr_en = 1'b1;
        end else if (pop_i) begin
            if (r_cnt != '0) begin
                w_tos_n = w_tos_dec;
                w_cnt_n = r_cnt - CW'(1);
            end else begin
                w_unf_n = 1'b1;
            end
        end
    end

    // Next checkpoint-valid vector. Frees apply before the set, and the allocated
    // id was free before the edge, so it can never be one freed this cycle.
    always_comb begin
        w_cv_n = r_cv;
        if (w_restore_ok) begin
            w_cv_n[restore_id_i] = 1'b0;
        end
        if (release_i) begin
            w_cv_n[release_id_i] = 1'b0;
        end
        if (w_take) begin
            w_cv_n[w_id] = 1'b1;
        end
        if (flush_i) begin
            w_cv_n = '0;
        end
    end

    // Stack storage, pointers, pulses and checkpoint valid bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
            r_tos <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_cv  <= '0;
        end else begin
            r_tos <= w_tos_n;
            r_cnt <= w_cnt_n;
            r_ovf <= w_ovf_n;
            r_unf <= w_unf_n;
            r_cv  <= w_cv_n;
            if (w_wr_en) begin
                r_ent[w_wr_idx] <= w_wr_data;
            end
        end
    end

    // Checkpoint payload captures the pre-update state. It is only read while
    // its valid bit is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_take) begin
            r_ck_tos[w_id] <= r_tos;
            r_ck_cnt[w_id] <= r_cnt;
            r_ck_top[w_id] <= r_ent[r_tos];
        end
    end

    assign top_o       = r_ent[r_tos];
    assign top_valid_o = (r_cnt != '0);
    assign overflow_o  = r_ovf;
    assign underflow_o = r_unf;
    assign ckpt_gnt_o  = w_gnt;
    assign ckpt_id_o   = w_id;

endmodule
